// File: rtl/neg_unit_pipe.sv
// Two-stage negate/complement/abs pipeline with valid/ready on both sides
// and a modulo counter of consumed results.
module neg_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] done_cnt
);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_adv, in_xfer, out_xfer, is_min;
    logic [WIDTH-1:0] twos, res;
    logic             res_ovf;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and an offered result holds until taken.
    assign out_xfer  = s2_valid_q && out_ready;
    assign s2_adv    = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_adv;
    assign in_xfer   = in_valid && in_ready;

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_ovf   = s2_ovf_q;
    assign done_cnt  = cnt_q;

    assign twos   = ~s1_data_q + ONE_W;
    assign is_min = (s1_data_q == MOST_NEG);

    always_comb begin
        res     = s1_data_q;
        res_ovf = 1'b0;
        case (s1_mode_q)
            2'b00: res = s1_data_q;
            2'b01: res = ~s1_data_q;
            2'b10: begin
                res     = is_min ? s1_data_q : twos;
                res_ovf = is_min;
            end
            default: begin
                // Most-negative value has no positive counterpart: pass it and flag.
                res     = (s1_data_q[WIDTH-1] && !is_min) ? twos : s1_data_q;
                res_ovf = is_min;
            end
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ovf_d   = s2_ovf_q;
        cnt_d      = cnt_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = res;
                s2_ovf_d  = res_ovf;
            end
        end
        // in_ready implies S1 is empty or is being drained into S2 this edge.
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_xfer) begin
            s1_data_d = in_data;
            s1_mode_d = mode;
        end
        if (out_xfer) begin
            cnt_d = cnt_q + ONE_C;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mode_q  <= 2'b00;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: doc/neg_unit_pipe.md
NEG_UNIT_PIPE -- requirements
Module: neg_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter CNT_W, default 8, width of the completed-transaction counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port in_valid, input, 1, upstream offers in_data/mode this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts the offer this cycle.
REQ-007 SHALL have port in_data, input, WIDTH, operand.
REQ-008 SHALL have port mode, input, 2, operation: 00 pass, 01 ones' complement, 10 two's complement, 11 absolute value.
REQ-009 SHALL have port out_valid, output, 1, out_data/out_ovf hold a result.
REQ-010 SHALL have port out_ready, input, 1, downstream consumes the result this cycle.
REQ-011 SHALL have port out_data, output, WIDTH, result.
REQ-012 SHALL have port out_ovf, output, 1, result not representable (two's/abs of most-negative value).
REQ-013 SHALL have port done_cnt, output, CNT_W, number of results consumed, modulo 2^CNT_W.

Function
REQ-014 SHALL implement a two-stage pipeline: stage S1 registers in_data and mode; stage S2 (the output register) registers the computed result and ovf.
REQ-015 SHALL perform a transfer on an input only when in_valid && in_ready at a rising edge, and on an output only when out_valid && out_ready at a rising edge.
REQ-016 SHALL compute combinationally between S1 and S2: pass = d; ones' = ~d; two's = ~d + 1 truncated to WIDTH; abs = two's if d[WIDTH-1]==1, else d.
REQ-017 SHALL set ovf=1 only when mode is 10 or 11 and d == {1'b1, (WIDTH-1){1'b0}}; result is then d unchanged; ovf=0 for modes 00/01.
REQ-018 SHALL advance S2 (load from S1, or clear valid) when S2 is empty or its output transfers this cycle.
REQ-019 SHALL drive in_ready = !S1.valid || S2 advances this cycle (combinational, no bubble at full throughput).
REQ-020 SHALL give latency of exactly 2 rising edges from input transfer to out_valid high when out_ready stays 1; throughput 1 result per cycle.
REQ-021 SHALL hold out_data, out_ovf and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL, when both stages are full and out_ready=0, drive in_ready=0 and drop/duplicate nothing; order is strictly FIFO.
REQ-023 SHALL, on a simultaneous output transfer and input transfer with full pipeline, shift S1->S2 and load S1 in the same edge.
REQ-024 SHALL increment done_cnt by 1 on each output transfer, wrapping 2^CNT_W-1 -> 0.
REQ-025 SHALL keep out_data and out_ovf at their last values when out_valid is 0 (no required clearing).

Reset
REQ-026 SHALL, while rst==0 (asynchronously), force S1.valid=0, out_valid=0, out_data=0, out_ovf=0, done_cnt=0; in_ready=1 once rst releases.
REQ-027 SHALL discard all in-flight data on reset asserted mid-operation; no result appears after release without a new input transfer.

Verification
REQ-028 SHALL be verified by: reset pulse -> out_valid=0, out_data=0x0000, out_ovf=0, done_cnt=0, in_ready=1.
REQ-029 SHALL be verified by: mode=01 in_data=0x00FF, out_ready=1 -> out_data=0xFF00, ovf=0, out_valid 2 edges after accept; mode=00 0x1234 -> 0x1234.
REQ-030 SHALL be verified by: mode=10 0x0001 -> 0xFFFF ovf=0; mode=10 0x8000 -> 0x8000 ovf=1; mode=11 0xFFFE -> 0x0002; mode=11 0x0005 -> 0x0005; mode=11 0x8000 -> 0x8000 ovf=1.
REQ-031 SHALL be verified by: stream 0x0001,0x0002,0x0003 (mode=01) with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, outputs 0xFFFE,0xFFFD,0xFFFC in order once out_ready=1, none lost or repeated.
REQ-032 SHALL be verified by: 256 consumed results with CNT_W=8 -> done_cnt reads 0x00 after wrap from 0xFF.
REQ-033 SHALL be verified by: rst=0 asserted with both stages full -> out_valid=0 immediately (before next edge), done_cnt=0, no stale result after release; plus 200+ random cycles vs. a reference model with random in_valid/out_ready.
